// File: rtl/led_pwm_pkg.sv
// Shared constants and types for the AXI-Lite LED controller:
// register offsets, channel modes and AXI response codes.
package led_pwm_pkg;

    localparam int OFF_CTRL       = 'h00;
    localparam int OFF_PRESCALE   = 'h04;
    localparam int OFF_BLINK_HALF = 'h08;
    localparam int OFF_STATUS     = 'h0C;
    localparam int OFF_CH_BASE    = 'h40;

    localparam int WORD_CTRL       = OFF_CTRL >> 2;
    localparam int WORD_PRESCALE   = OFF_PRESCALE >> 2;
    localparam int WORD_BLINK_HALF = OFF_BLINK_HALF >> 2;
    localparam int WORD_STATUS     = OFF_STATUS >> 2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_PWM   = 2'd3
    } led_mode_e;

    // Word index of channel register ch.
    function automatic int ch_word(input int ch);
        return (OFF_CH_BASE >> 2) + ch;
    endfunction

endpackage

// File: rtl/led_timebase.sv
// Shared timebase: prescaler tick, free-running PWM counter and blink phase.
// Everything is held at zero while en is low.
module led_timebase
    import led_pwm_pkg::*;
#(
    parameter int PWM_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [15:0]      prescale,
    input  logic [15:0]      blink_half,
    output logic             tick,
    output logic [PWM_W-1:0] pwm_cnt,
    output logic             period_start,
    output logic             blink_phase
);
    logic [15:0]      presc_cnt_reg;
    logic [15:0]      blink_cnt_reg;
    logic [PWM_W-1:0] pwm_cnt_reg;
    logic             blink_phase_reg;
    logic [15:0]      limit;

    // A prescale of zero would mean a tick every cycle with no idle state; clamp to 1.
    assign limit        = (prescale == 16'd0) ? 16'd1 : prescale;
    assign tick         = en & (presc_cnt_reg >= limit);
    assign period_start = tick & (pwm_cnt_reg == {PWM_W{1'b1}});
    assign pwm_cnt      = pwm_cnt_reg;
    assign blink_phase  = blink_phase_reg;

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            presc_cnt_reg   <= '0;
            pwm_cnt_reg     <= '0;
            blink_cnt_reg   <= '0;
            blink_phase_reg <= 1'b0;
        end else begin
            presc_cnt_reg <= tick ? 16'd0 : presc_cnt_reg + 16'd1;
            if (tick) begin
                pwm_cnt_reg <= pwm_cnt_reg + 1'b1;
            end
            if (period_start) begin
                if (blink_cnt_reg >= blink_half) begin
                    blink_cnt_reg   <= '0;
                    blink_phase_reg <= ~blink_phase_reg;
                end else begin
                    blink_cnt_reg <= blink_cnt_reg + 16'd1;
                end
            end
        end
    end

endmodule

// File: rtl/axil_led_pwm.sv
// AXI4-Lite slave with register file and handshakes driving NUM_LEDS LEDs,
// each independently off, on, blinking or PWM-dimmed.
module axil_led_pwm
    import led_pwm_pkg::*;
#(
    parameter int NUM_LEDS = 8,
    parameter int ADDR_W   = 8,
    parameter int PWM_W    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                s_axil_awvalid,
    output logic                s_axil_awready,
    input  logic [ADDR_W-1:0]   s_axil_awaddr,
    input  logic [2:0]          s_axil_awprot,
    input  logic                s_axil_wvalid,
    output logic                s_axil_wready,
    input  logic [31:0]         s_axil_wdata,
    input  logic [3:0]          s_axil_wstrb,
    output logic                s_axil_bvalid,
    input  logic                s_axil_bready,
    output logic [1:0]          s_axil_bresp,
    input  logic                s_axil_arvalid,
    output logic                s_axil_arready,
    input  logic [ADDR_W-1:0]   s_axil_araddr,
    input  logic [2:0]          s_axil_arprot,
    output logic                s_axil_rvalid,
    input  logic                s_axil_rready,
    output logic [31:0]         s_axil_rdata,
    output logic [1:0]          s_axil_rresp,
    output logic [NUM_LEDS-1:0] LED
);
    localparam int IDX_W = ADDR_W - 2;

    logic                ctrl_en_reg;
    logic [15:0]         prescale_reg;
    logic [15:0]         blink_half_reg;
    logic [NUM_LEDS-1:0] led_reg;
    logic [NUM_LEDS-1:0] led_next;
    logic                primed_reg;
    logic                bvalid_reg;
    logic [1:0]          bresp_reg;
    logic                rvalid_reg;
    logic [31:0]         rdata_reg;
    logic [1:0]          rresp_reg;

    logic                wr_accept;
    logic                rd_accept;
    logic [IDX_W-1:0]    wr_idx;
    logic [IDX_W-1:0]    rd_idx;
    logic                wr_ctrl;
    logic                wr_prescale;
    logic                wr_blink;
    logic                wr_ok;
    logic [NUM_LEDS-1:0] wr_ch_sel;
    logic [31:0]         ch_image [NUM_LEDS];
    logic [31:0]         rd_data_next;
    logic                rd_hit;

    logic                tick;
    logic                period_start;
    logic                blink_phase;
    logic                load;
    logic [PWM_W-1:0]    pwm_cnt;
    logic                unused_bits;

    assign unused_bits = ^{s_axil_awprot, s_axil_arprot, s_axil_awaddr[1:0],
                           s_axil_araddr[1:0], s_axil_wdata[31:16], s_axil_wstrb[3:2]};

    // Write channel: AW and W are only ever taken together, one outstanding B.
    assign wr_accept      = s_axil_awvalid & s_axil_wvalid & ~bvalid_reg;
    assign s_axil_awready = wr_accept;
    assign s_axil_wready  = wr_accept;
    assign s_axil_bvalid  = bvalid_reg;
    assign s_axil_bresp   = bresp_reg;

    assign wr_idx      = s_axil_awaddr[ADDR_W-1:2];
    assign wr_ctrl     = (wr_idx == IDX_W'(WORD_CTRL));
    assign wr_prescale = (wr_idx == IDX_W'(WORD_PRESCALE));
    assign wr_blink    = (wr_idx == IDX_W'(WORD_BLINK_HALF));
    assign wr_ok       = wr_ctrl | wr_prescale | wr_blink | (|wr_ch_sel);

    assign s_axil_arready = ~rvalid_reg & ~rst;
    assign rd_accept      = s_axil_arvalid & s_axil_arready;
    assign s_axil_rvalid  = rvalid_reg;
    assign s_axil_rdata   = rdata_reg;
    assign s_axil_rresp   = rresp_reg;
    assign rd_idx         = s_axil_araddr[ADDR_W-1:2];

    assign LED = led_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_en_reg    <= 1'b0;
            prescale_reg   <= 16'd1;
            blink_half_reg <= '0;
        end else if (wr_accept) begin
            if (wr_ctrl && s_axil_wstrb[0]) begin
                ctrl_en_reg <= s_axil_wdata[0];
            end
            if (wr_prescale) begin
                if (s_axil_wstrb[0]) prescale_reg[7:0]  <= s_axil_wdata[7:0];
                if (s_axil_wstrb[1]) prescale_reg[15:8] <= s_axil_wdata[15:8];
            end
            if (wr_blink) begin
                if (s_axil_wstrb[0]) blink_half_reg[7:0]  <= s_axil_wdata[7:0];
                if (s_axil_wstrb[1]) blink_half_reg[15:8] <= s_axil_wdata[15:8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bvalid_reg <= 1'b0;
            bresp_reg  <= RESP_OKAY;
        end else if (wr_accept) begin
            bvalid_reg <= 1'b1;
            bresp_reg  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
        end else if (s_axil_bready) begin
            bvalid_reg <= 1'b0;
        end
    end

    always_comb begin
        rd_data_next = '0;
        rd_hit       = 1'b1;
        if (rd_idx == IDX_W'(WORD_CTRL)) begin
            rd_data_next = {31'd0, ctrl_en_reg};
        end else if (rd_idx == IDX_W'(WORD_PRESCALE)) begin
            rd_data_next = {16'd0, prescale_reg};
        end else if (rd_idx == IDX_W'(WORD_BLINK_HALF)) begin
            rd_data_next = {16'd0, blink_half_reg};
        end else if (rd_idx == IDX_W'(WORD_STATUS)) begin
            rd_data_next = 32'(led_reg);
        end else begin
            rd_hit = 1'b0;
            for (int i = 0; i < NUM_LEDS; i++) begin
                if (rd_idx == IDX_W'(ch_word(i))) begin
                    rd_data_next = ch_image[i];
                    rd_hit       = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid_reg <= 1'b0;
            rdata_reg  <= '0;
            rresp_reg  <= RESP_OKAY;
        end else if (rd_accept) begin
            rvalid_reg <= 1'b1;
            rdata_reg  <= rd_data_next;
            rresp_reg  <= rd_hit ? RESP_OKAY : RESP_SLVERR;
        end else if (s_axil_rready) begin
            rvalid_reg <= 1'b0;
        end
    end

    led_timebase #(
        .PWM_W(PWM_W)
    ) u_timebase (
        .clk         (clk),
        .rst         (rst),
        .en          (ctrl_en_reg),
        .prescale    (prescale_reg),
        .blink_half  (blink_half_reg),
        .tick        (tick),
        .pwm_cnt     (pwm_cnt),
        .period_start(period_start),
        .blink_phase (blink_phase)
    );

    // While disabled the active copies simply follow the registers, so the first
    // cycle after enable already drives the programmed mode.
    always_ff @(posedge clk) begin
        if (rst || !ctrl_en_reg) begin
            primed_reg <= 1'b0;
        end else if (tick) begin
            primed_reg <= 1'b1;
        end
    end

    assign load = ~ctrl_en_reg | period_start | (tick & ~primed_reg);

    genvar gi;
    for (gi = 0; gi < NUM_LEDS; gi++) begin : g_ch
        logic [1:0]       mode_reg;
        logic [PWM_W-1:0] duty_reg;
        led_mode_e        mode_active_reg;
        logic [PWM_W-1:0] duty_active_reg;
        logic             drive;

        assign wr_ch_sel[gi] = (wr_idx == IDX_W'(ch_word(gi)));
        assign ch_image[gi]  = (32'(duty_reg) << 8) | 32'(mode_reg);

        // DUTY sits in byte 1, MODE in byte 0.
        always_ff @(posedge clk) begin
            if (rst) begin
                mode_reg <= '0;
                duty_reg <= '0;
            end else if (wr_accept && wr_ch_sel[gi]) begin
                if (s_axil_wstrb[0]) mode_reg <= s_axil_wdata[1:0];
                if (s_axil_wstrb[1]) duty_reg <= s_axil_wdata[8 +: PWM_W];
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                mode_active_reg <= MODE_OFF;
                duty_active_reg <= '0;
            end else if (load) begin
                mode_active_reg <= led_mode_e'(mode_reg);
                duty_active_reg <= duty_reg;
            end
        end

        always_comb begin
            drive = 1'b0;
            case (mode_active_reg)
                MODE_ON:    drive = 1'b1;
                MODE_BLINK: drive = blink_phase;
                MODE_PWM:   drive = (pwm_cnt < duty_active_reg);
                default:    drive = 1'b0;
            endcase
        end

        assign led_next[gi] = ctrl_en_reg & drive;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            led_reg <= '0;
        end else begin
            led_reg <= led_next;
        end
    end

endmodule

// File: tb/tb_axil_led_pwm.sv
// Directed bench for axil_led_pwm: register access, error responses,
// backpressure, strobes and measured on/blink/PWM waveforms.
`timescale 1ns/1ps
module tb_axil_led_pwm;
    import led_pwm_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        awvalid = 1'b0, awready;
    logic [7:0]  awaddr = '0;
    logic [2:0]  awprot = '0;
    logic        wvalid = 1'b0, wready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        bvalid, bready = 1'b0;
    logic [1:0]  bresp;
    logic        arvalid = 1'b0, arready;
    logic [7:0]  araddr = '0;
    logic [2:0]  arprot = '0;
    logic        rvalid, rready = 1'b0;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic [7:0]  led;

    int tests = 0;
    int failed = 0;
    int cyc = 0;

    axil_led_pwm #(.NUM_LEDS(8), .ADDR_W(8), .PWM_W(8)) dut (
        .clk(clk), .rst(rst),
        .s_axil_awvalid(awvalid), .s_axil_awready(awready), .s_axil_awaddr(awaddr),
        .s_axil_awprot(awprot),
        .s_axil_wvalid(wvalid), .s_axil_wready(wready), .s_axil_wdata(wdata),
        .s_axil_wstrb(wstrb),
        .s_axil_bvalid(bvalid), .s_axil_bready(bready), .s_axil_bresp(bresp),
        .s_axil_arvalid(arvalid), .s_axil_arready(arready), .s_axil_araddr(araddr),
        .s_axil_arprot(arprot),
        .s_axil_rvalid(rvalid), .s_axil_rready(rready), .s_axil_rdata(rdata),
        .s_axil_rresp(rresp),
        .LED(led)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic axi_write(input logic [7:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
        int n;
        @(posedge clk); #1;
        awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!awready && n < 50) begin @(negedge clk); n++; end
        chk("wr_awready", 32'(awready), 32'd1);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
        n = 0;
        @(negedge clk);
        while (!bvalid && n < 50) begin @(negedge clk); n++; end
        chk("wr_bvalid", 32'(bvalid), 32'd1);
        resp = bresp;
        @(posedge clk); #1;
        bready = 1'b0;
        $display("[TB] WR addr=0x%02h data=0x%08h strb=%b resp=%b", addr, data, strb, resp);
    endtask

    task automatic axi_read(input logic [7:0] addr, output logic [31:0] data,
                            output logic [1:0] resp);
        int n;
        @(posedge clk); #1;
        araddr = addr; arvalid = 1'b1; rready = 1'b1;
        n = 0;
        @(negedge clk);
        while (!arready && n < 50) begin @(negedge clk); n++; end
        chk("rd_arready", 32'(arready), 32'd1);
        @(posedge clk); #1;
        arvalid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!rvalid && n < 50) begin @(negedge clk); n++; end
        chk("rd_rvalid", 32'(rvalid), 32'd1);
        data = rdata;
        resp = rresp;
        @(posedge clk); #1;
        rready = 1'b0;
        $display("[TB] RD addr=0x%02h data=0x%08h resp=%b", addr, data, resp);
    endtask

    // Returns the cycle count at the first negedge where led[idx] equals val.
    task automatic wait_led(input int idx, input logic val, input int max_cyc,
                            input string tag, output int at);
        int n;
        n = 0;
        @(negedge clk);
        while (led[idx] !== val && n < max_cyc) begin @(negedge clk); n++; end
        chk(tag, 32'(led[idx]), 32'(val));
        at = cyc;
    endtask

    initial begin
        logic [31:0] d;
        logic [1:0]  r;
        int t0, t1, t2, t3, n;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_led", 32'(led), 32'h0);
        chk("rst_awready", 32'(awready), 32'h0);
        chk("rst_arready", 32'(arready), 32'h0);
        chk("rst_bvalid", 32'(bvalid), 32'h0);
        chk("rst_rvalid", 32'(rvalid), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        axi_read(8'h04, d, r);
        chk("rst_prescale", d, 32'h1);
        chk("rst_prescale_resp", 32'(r), 32'(RESP_OKAY));
        axi_read(8'h0C, d, r);
        chk("rst_status", d, 32'h0);
        chk("rst_status_resp", 32'(r), 32'(RESP_OKAY));

        // Static on
        axi_write(8'h48, 32'h0000_0001, 4'hF, r);
        chk("ch2_wr_resp", 32'(r), 32'(RESP_OKAY));
        chk("ch2_led_before_en", 32'(led), 32'h0);
        axi_write(8'h00, 32'h1, 4'hF, r);
        chk("on_led", 32'(led), 32'h04);
        axi_read(8'h0C, d, r);
        chk("on_status", d, 32'h04);
        axi_read(8'h48, d, r);
        chk("ch2_readback", d, 32'h1);

        // Disable clears LEDs; then PWM at duty 128 with PRESCALE=0 (acts as 1)
        axi_write(8'h00, 32'h0, 4'hF, r);
        chk("en_off_led", 32'(led), 32'h0);
        axi_write(8'h48, 32'h0, 4'hF, r);
        axi_write(8'h04, 32'h0, 4'hF, r);
        axi_read(8'h04, d, r);
        chk("prescale_zero_rb", d, 32'h0);
        axi_write(8'h40, 32'h0000_8003, 4'hF, r);
        axi_write(8'h00, 32'h1, 4'hF, r);
        repeat (20) @(negedge clk);
        n = 0;
        for (int k = 0; k < 512; k++) begin
            @(negedge clk);
            if (led[0]) n++;
        end
        chk("pwm128_high_cycles", 32'(n), 32'd256);

        // Duty rewrite mid-period: current period keeps duty 128 (256 cycles high)
        wait_led(0, 1'b0, 600, "pwm_wait_low", t0);
        wait_led(0, 1'b1, 600, "pwm_wait_rise", t0);
        axi_write(8'h40, 32'h0000_4003, 4'hF, r);
        wait_led(0, 1'b0, 600, "pwm_wait_fall", t1);
        chk("pwm_old_duty_high", 32'(t1 - t0), 32'd256);
        wait_led(0, 1'b1, 600, "pwm_wait_rise2", t2);
        chk("pwm_old_duty_low", 32'(t2 - t1), 32'd256);
        wait_led(0, 1'b0, 600, "pwm_wait_fall2", t3);
        chk("pwm_new_duty_high", 32'(t3 - t2), 32'd128);

        // Blink: BLINK_HALF=2 -> toggle every 3 periods of 512 cycles
        axi_write(8'h00, 32'h0, 4'hF, r);
        axi_write(8'h40, 32'h0, 4'hF, r);
        axi_write(8'h08, 32'h2, 4'hF, r);
        axi_write(8'h44, 32'h2, 4'hF, r);
        axi_write(8'h00, 32'h1, 4'hF, r);
        wait_led(1, 1'b1, 2000, "blink_wait_rise", t0);
        wait_led(1, 1'b0, 2000, "blink_wait_fall", t1);
        chk("blink_high_len", 32'(t1 - t0), 32'd1536);
        wait_led(1, 1'b1, 2000, "blink_wait_rise2", t2);
        chk("blink_low_len", 32'(t2 - t1), 32'd1536);
        axi_write(8'h00, 32'h0, 4'hF, r);
        chk("blink_off_led", 32'(led), 32'h0);

        // Error responses
        axi_write(8'h3C, 32'hFFFF_FFFF, 4'hF, r);
        chk("unmapped_wr_resp", 32'(r), 32'(RESP_SLVERR));
        axi_write(8'h0C, 32'hFFFF_FFFF, 4'hF, r);
        chk("status_wr_resp", 32'(r), 32'(RESP_SLVERR));
        axi_read(8'h0C, d, r);
        chk("status_after_wr", d, 32'h0);
        axi_read(8'h3C, d, r);
        chk("unmapped_rd_data", d, 32'h0);
        chk("unmapped_rd_resp", 32'(r), 32'(RESP_SLVERR));
        axi_read(8'h60, d, r);
        chk("ch8_rd_resp", 32'(r), 32'(RESP_SLVERR));
        axi_read(8'h00, d, r);
        chk("ctrl_unchanged", d, 32'h0);
        axi_read(8'h08, d, r);
        chk("blink_half_unchanged", d, 32'h2);

        // Write backpressure: second AW+W stalls while B is pending
        @(posedge clk); #1;
        awaddr = 8'h4C; wdata = 32'h0000_2001; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        @(negedge clk);
        chk("bp_first_ready", 32'(awready), 32'h1);
        @(posedge clk); #1;
        awaddr = 8'h50; wdata = 32'h0000_3002;
        repeat (4) @(negedge clk);
        chk("bp_awready_held", 32'(awready), 32'h0);
        chk("bp_wready_held", 32'(wready), 32'h0);
        chk("bp_bvalid_held", 32'(bvalid), 32'h1);
        bready = 1'b1;
        @(negedge clk);
        chk("bp_second_ready", 32'(awready), 32'h1);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        @(negedge clk);
        chk("bp_second_bvalid", 32'(bvalid), 32'h1);
        @(posedge clk); #1;
        bready = 1'b0;
        $display("[TB] WR backpressure pair to 0x4C/0x50 done");
        axi_read(8'h4C, d, r);
        chk("bp_ch3_rb", d, 32'h0000_2001);
        axi_read(8'h50, d, r);
        chk("bp_ch4_rb", d, 32'h0000_3002);

        // Byte strobes: only DUTY byte updated
        axi_write(8'h40, 32'h0000_0003, 4'hF, r);
        axi_write(8'h40, 32'hFFFF_AB02, 4'b0010, r);
        axi_read(8'h40, d, r);
        chk("strb_duty_only", d, 32'h0000_AB03);

        // Reset during a pending read response
        @(posedge clk); #1;
        araddr = 8'h04; arvalid = 1'b1; rready = 1'b0;
        @(posedge clk); #1;
        arvalid = 1'b0;
        @(negedge clk);
        chk("mid_rvalid_pending", 32'(rvalid), 32'h1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rvalid_dropped", 32'(rvalid), 32'h0);
        $display("[TB] RD addr=0x04 dropped by reset");
        axi_read(8'h04, d, r);
        chk("mid_prescale_reset", d, 32'h1);
        axi_read(8'h4C, d, r);
        chk("mid_ch3_reset", d, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
